mult_hilo_ctrl: RTL
===================

MULT_HILO_CTRL -- requirements
Module: mult_hilo_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYC, default 64, the watchdog limit in cycles while waiting for the multiplier.
REQ-002 SHALL have port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ex_op  in  3  EX-stage op (NOP, MULT, MULTU, MTHI, MTLO, MFHI, MFLO).
REQ-005 SHALL have port: ex_opa / ex_opb  in  32 each  rs / rt operand values.
REQ-006 SHALL have port: flush  in  1  pipeline flush.
REQ-007 SHALL have port: mult_done  in  1 / mult_result  in  64  handshake and product from the Booth multiplier; the product is signed.
REQ-008 SHALL have port: mult_start  out  1 / mult_op1, mult_op2  out  32 each  drive the Booth multiplier.
REQ-009 SHALL have port: stall_req  out  1  request a pipeline stall.
REQ-010 SHALL have port: hilo_rdata  out  32  MFHI/MFLO result.
REQ-011 SHALL have ports: hi, lo  out  32 each / mult_err  out  1.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, FIX.
REQ-013 IDLE, ex_op MULT/MULTU, no flush: SHALL latch opa/opb and an unsigned flag, assert stall_req combinationally in that cycle, and go to BUSY.
REQ-014 BUSY: SHALL hold mult_start=1 and mult_op1/op2 at the latched operands, and hold stall_req=1.
REQ-015 BUSY with mult_done=1: SHALL capture mult_result, drop mult_start, and go to FIX.
REQ-016 FIX: SHALL apply the correction, write HI/LO, hold stall_req=0, ignore ex_op, and return to IDLE next cycle.
REQ-017 Signed (MULT): SHALL write HI=result[63:32] and LO=result[31:0].
REQ-018 Unsigned (MULTU): SHALL write HI=result[63:32] + (opa[31]?opb:0) + (opb[31]?opa:0) mod 2^32, and LO unchanged from the product.
REQ-019 Latency: SHALL update HI/LO at the end of the FIX cycle, i.e. mult_done cycle + 1.
REQ-020 MTHI/MTLO in IDLE: SHALL write opa to HI/LO at the clock edge, with no stall.
REQ-021 hilo_rdata: SHALL be combinational, equal to hi for MFHI, lo for MFLO, and 0 otherwise.
REQ-022 MFHI/MFLO are never issued during BUSY because the pipeline is stalled, so no bypass is required.
REQ-023 flush in any state: SHALL return to IDLE next cycle with mult_start=0 and no HI/LO write; flush takes priority over mult_done.
REQ-024 mult_done in IDLE or FIX: SHALL be ignored.

Reset
REQ-025 rst=0: SHALL force state=IDLE, hi=lo=0, mult_start=0, mult_op1=mult_op2=0, mult_err=0, and clear the timeout counter.
REQ-026 Reset during BUSY: SHALL abandon the operation with no partial HI/LO write; stall_req SHALL read 0 while in reset.

Configuration
REQ-027 With MULT_TIMEOUT_EN defined: a counter SHALL run in BUSY; if it reaches TIMEOUT_CYC without mult_done, the block SHALL go to IDLE, drop mult_start and stall_req, leave HI/LO unchanged, and set mult_err.
REQ-028 mult_err SHALL be sticky until the next MULT/MULTU is accepted.
REQ-029 Without MULT_TIMEOUT_EN: there SHALL be no counter, mult_err SHALL be tied to 0, and BUSY SHALL wait indefinitely.

Structure
REQ-030 The shared defines header SHALL hold the ex_op encodings, the state encodings and the default timeout constant.
REQ-031 The HI/LO register pair (two write ports, priority FIX > MTHI/MTLO) SHALL be a sub-module named hilo_reg; the FSM and correction logic stay in mult_hilo_ctrl.

Verification
REQ-032 MULT opa=0x000000FF, opb=0x800000FF, model returns the signed product after 8 cycles -> HI=0xFFFFFF80, LO=0x8000FE01; stall high 9 cycles, low in FIX.
REQ-033 MULTU with the same operands -> HI=0x0000007F, LO=0x8000FE01.
REQ-034 MTHI 0x12345678, then MFHI next cycle -> hilo_rdata=0x12345678, stall_req never asserted.
REQ-035 MULT accepted, flush on 3rd BUSY cycle, then late mult_done -> HI/LO unchanged, state IDLE, mult_start=0.
REQ-036 rst low for 1 cycle mid-BUSY -> all outputs at reset values immediately; next MULT completes normally.
REQ-037 With MULT_TIMEOUT_EN, mult_done never asserted -> after 64 BUSY cycles mult_err=1 and stall_req=0; the next MULT clears mult_err.

Source files
------------

// File: rtl/mult_hilo_ctrl_pkg.sv
// rtl/mult_hilo_ctrl_pkg.sv - ex_op and state encodings, default watchdog limit, MULTU high-word fix-up
package mult_hilo_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_MTHI  = 3'd3,
    OP_MTLO  = 3'd4,
    OP_MFHI  = 3'd5,
    OP_MFLO  = 3'd6
  } ex_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  localparam int TIMEOUT_CYC_DEFAULT = 64;

  // The multiplier is signed; reading its operands as unsigned adds back each operand whose partner is negative.
  function automatic logic [31:0] multu_hi_fix(input logic [31:0] hi_signed,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    logic [31:0] add_a;
    logic [31:0] add_b;
    add_a = b[31] ? a : 32'd0;
    add_b = a[31] ? b : 32'd0;
    return hi_signed + add_a + add_b;
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// rtl/hilo_reg.sv - HI/LO register pair; multiply write-back wins over MTHI/MTLO
module hilo_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        fix_we,
  input  logic [31:0] fix_hi,
  input  logic [31:0] fix_lo,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] mt_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (fix_we) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else begin
      if (mthi_we) hi <= mt_data;
      if (mtlo_we) lo <= mt_data;
    end
  end

endmodule

// File: rtl/mult_hilo_ctrl.sv
// rtl/mult_hilo_ctrl.sv - MULT/MULTU sequencing, MTHI/MTLO/MFHI/MFLO handling for the Booth multiplier
// MULT_TIMEOUT_EN adds a BUSY watchdog that aborts the operation and raises a sticky mult_err.
module mult_hilo_ctrl
  import mult_hilo_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_opa,
  input  logic [31:0] ex_opb,
  input  logic        flush,
  input  logic        mult_done,
  input  logic [63:0] mult_result,
  output logic        mult_start,
  output logic [31:0] mult_op1,
  output logic [31:0] mult_op2,
  output logic        stall_req,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mult_err
);

  state_e      state_q;
  state_e      state_d;
  ex_op_e      op;
  logic        in_idle;
  logic        in_busy;
  logic        in_fix;
  logic        is_mult;
  logic        accept;
  logic        uns_q;
  logic [63:0] res_q;
  logic        timeout_hit;
  logic        fix_we;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] fix_hi;

  assign op      = ex_op_e'(ex_op);
  assign in_idle = (state_q == ST_IDLE);
  assign in_busy = (state_q == ST_BUSY);
  assign in_fix  = (state_q == ST_FIX);
  assign is_mult = (op == OP_MULT) || (op == OP_MULTU);
  assign accept  = in_idle && !flush && is_mult;

`ifdef MULT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  assign timeout_hit = in_busy && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (in_busy && state_d == ST_BUSY) ? tmo_cnt + 1'b1 : '0;
      if (accept)
        err_q <= 1'b0;
      else if (timeout_hit && !mult_done && !flush)
        err_q <= 1'b1;
    end
  end

  assign mult_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mult_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (is_mult) state_d = ST_BUSY;
        ST_BUSY: begin
          if (mult_done)        state_d = ST_FIX;
          else if (timeout_hit) state_d = ST_IDLE;
        end
        ST_FIX:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // The stall must be visible in the accept cycle itself, but never while reset is held.
  always_comb begin
    mult_start = in_busy;
    stall_req  = rst && (accept || in_busy);
    fix_we     = in_fix && !flush;
    mthi_we    = in_idle && !flush && (op == OP_MTHI);
    mtlo_we    = in_idle && !flush && (op == OP_MTLO);
    hilo_rdata = 32'd0;
    if (op == OP_MFHI)      hilo_rdata = hi;
    else if (op == OP_MFLO) hilo_rdata = lo;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_op1 <= 32'd0;
      mult_op2 <= 32'd0;
      uns_q    <= 1'b0;
      res_q    <= 64'd0;
    end else begin
      if (accept) begin
        mult_op1 <= ex_opa;
        mult_op2 <= ex_opb;
        uns_q    <= (op == OP_MULTU);
      end
      if (in_busy && mult_done && !flush) res_q <= mult_result;
    end
  end

  assign fix_hi = uns_q ? multu_hi_fix(res_q[63:32], mult_op1, mult_op2) : res_q[63:32];

  hilo_reg u_hilo (
    .clk     (clk),
    .rst     (rst),
    .fix_we  (fix_we),
    .fix_hi  (fix_hi),
    .fix_lo  (res_q[31:0]),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .mt_data (ex_opa),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
